// File: rtl/digit_string_renderer.sv
// Binary-to-BCD converter (iterative double-dabble) with double-buffered digits,
// plus font ROM addressing and registered pixel output for a row of 8x16 digit glyphs.
module digit_string_renderer #(
  parameter int unsigned NUM_DIGITS       = 5,
  parameter int unsigned VALUE_WIDTH      = 16,
  parameter bit          SUPPRESS_LEADING = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [VALUE_WIDTH-1:0]  value_in,
  input  logic                    load,
  output logic                    busy,
  output logic                    ready,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  input  logic [9:0]              origin_x,
  input  logic [9:0]              origin_y,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  output logic [7:0]              font_addr,
  input  logic [7:0]              font_data,
  output logic                    pixel_on
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(VALUE_WIDTH + 1);
  localparam int unsigned BOX_W = 8 * NUM_DIGITS;

  typedef enum logic {IDLE, CONVERT} state_e;

  state_e                 state_q, state_d;
  logic [VALUE_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]       scratch_q, scratch_d, scratch_adj;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0]       digits_q, digits_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   pixel_q, pixel_d;

  logic [9:0] relx, rely;
  logic [6:0] dig_idx;
  logic       in_box;
  logic [3:0] nib, sel_digit, code;
  logic       lead_zero, sel_blank;

  // Per-nibble add-3 correction; no carry between nibbles.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    ready_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d   = value_in;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        scratch_d = {scratch_adj[BCD_W-2:0], shift_q[VALUE_WIDTH-1]};
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
        // Last iteration commits the fully shifted result in the same edge.
        if (cnt_q == CNT_W'(VALUE_WIDTH - 1)) begin
          digits_d = scratch_d;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CONVERT);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      pixel_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      pixel_q   <= pixel_d;
    end
  end

  // Render addressing: negative offsets wrap large and land outside the box.
  always_comb begin
    relx      = DrawX - origin_x;
    rely      = DrawY - origin_y;
    in_box    = (relx < 10'(BOX_W)) && (rely < 10'd16);
    dig_idx   = relx[9:3];
    lead_zero = 1'b1;
    nib       = '0;
    sel_digit = '0;
    sel_blank = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      nib       = digits_q[4*(int'(NUM_DIGITS)-1-i) +: 4];
      lead_zero = lead_zero && (nib == 4'd0);
      if (dig_idx == 7'(i)) begin
        sel_digit = nib;
        sel_blank = SUPPRESS_LEADING && lead_zero && (i != int'(NUM_DIGITS) - 1);
      end
    end
    code      = sel_blank ? 4'd0 : sel_digit + 4'd1;
    font_addr = in_box ? {code, rely[3:0]} : 8'h00;
    pixel_d   = in_box && font_data[3'd7 - relx[2:0]];
  end

  assign busy       = busy_q;
  assign ready      = ready_q;
  assign digits_out = digits_q;
  assign pixel_on   = pixel_q;

endmodule

// File: tb/tb_digit_string_renderer.sv
// Self-checking bench for digit_string_renderer: fixed vectors, protocol corners,
// and random values/pixels compared against an arithmetic decimal/glyph model.
module tb_digit_string_renderer;

  localparam int ND = 5;
  localparam int VW = 16;

  logic        Clk, Reset_n;
  logic [15:0] value_in;
  logic        load;
  logic        busy, ready;
  logic [19:0] digits_out;
  logic [9:0]  origin_x, origin_y, DrawX, DrawY;
  logic [7:0]  font_addr, font_data;
  logic        pixel_on;

  int errors = 0;
  int checks = 0;
  int cur_val = 0;

  digit_string_renderer #(.NUM_DIGITS(ND), .VALUE_WIDTH(VW), .SUPPRESS_LEADING(1'b1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .value_in(value_in), .load(load),
    .busy(busy), .ready(ready), .digits_out(digits_out),
    .origin_x(origin_x), .origin_y(origin_y), .DrawX(DrawX), .DrawY(DrawY),
    .font_addr(font_addr), .font_data(font_data), .pixel_on(pixel_on)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Stand-in font ROM: blank code reads zero; one fixed glyph row, else the address itself.
  function automatic logic [7:0] rom(input logic [7:0] a);
    if (a[7:4] == 4'd0) return 8'h00;
    if (a == 8'h22) return 8'h18;
    return a;
  endfunction

  always_comb font_data = rom(font_addr);

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] model_addr(input int val, input int ox, input int oy,
                                            input int dx, input int dy);
    int relx, rely, idx, upper, code;
    relx = (dx - ox) & 1023;
    rely = (dy - oy) & 1023;
    if (relx >= 8*ND || rely >= 16) return 8'h00;
    idx   = relx / 8;
    upper = val / pow10(ND - 1 - idx);
    code  = (upper == 0 && idx < ND - 1) ? 0 : (upper % 10) + 1;
    return 8'(code * 16 + rely);
  endfunction

  function automatic logic model_pix(input int val, input int ox, input int oy,
                                     input int dx, input int dy);
    logic [7:0] a, g;
    int relx;
    a    = model_addr(val, ox, oy, dx, dy);
    g    = rom(a);
    relx = (dx - ox) & 1023;
    return g[7 - (relx % 8)];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic probe(input string nm, input int ox, input int oy, input int dx, input int dy,
                       input logic [7:0] ea, input logic ep);
    @(negedge Clk);
    origin_x = 10'(ox); origin_y = 10'(oy); DrawX = 10'(dx); DrawY = 10'(dy);
    #1 chk({nm, " font_addr"}, 32'(font_addr), 32'(ea));
    @(posedge Clk);
    #1 chk({nm, " pixel_on"}, 32'(pixel_on), 32'(ep));
  endtask

  task automatic convert(input int v);
    @(negedge Clk);
    value_in = 16'(v);
    load = 1'b1;
    @(posedge Clk);
    #1 load = 1'b0;
    chk("busy after accept", 32'(busy), 32'd1);
    for (int i = 1; i < VW; i++) begin
      @(posedge Clk);
      #1 chk("busy/ready during convert", {30'd0, busy, ready}, 32'b10);
    end
    @(posedge Clk);
    #1 chk("commit busy/ready", {30'd0, busy, ready}, 32'b01);
    chk("commit digits", 32'(digits_out), 32'(to_bcd(v)));
    @(posedge Clk);
    #1 chk("ready single pulse", 32'(ready), 32'd0);
    cur_val = v;
  endtask

  typedef struct {
    string      nm;
    int         val;
    int         ox, oy, dx, dy;
    logic [7:0] ea;
    logic       ep;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{"12345 msd left",   12345, 100, 50, 100, 52, 8'h22, 1'b0};
    vecs[1]  = '{"12345 msd col3",   12345, 100, 50, 103, 52, 8'h22, 1'b1};
    vecs[2]  = '{"12345 lsd last",   12345, 100, 50, 139, 61, 8'h6B, 1'b1};
    vecs[3]  = '{"oob left",         12345, 100, 50,  99, 52, 8'h00, 1'b0};
    vecs[4]  = '{"oob right",        12345, 100, 50, 140, 52, 8'h00, 1'b0};
    vecs[5]  = '{"oob above",        12345, 100, 50, 100, 49, 8'h00, 1'b0};
    vecs[6]  = '{"oob below",        12345, 100, 50, 100, 66, 8'h00, 1'b0};
    vecs[7]  = '{"42 blank d0",      42,    100, 50, 100, 52, 8'h02, 1'b0};
    vecs[8]  = '{"42 blank d1",      42,    100, 50, 110, 52, 8'h02, 1'b0};
    vecs[9]  = '{"42 blank d2 end",  42,    100, 50, 123, 52, 8'h02, 1'b0};
    vecs[10] = '{"42 digit 4",       42,    100, 50, 124, 52, 8'h52, 1'b0};
    vecs[11] = '{"42 digit 4 col3",  42,    100, 50, 127, 52, 8'h52, 1'b1};
    vecs[12] = '{"42 digit 2",       42,    100, 50, 132, 52, 8'h32, 1'b0};
    vecs[13] = '{"42 digit 2 col2",  42,    100, 50, 134, 52, 8'h32, 1'b1};
    vecs[14] = '{"0 blank d0",       0,     100, 50, 100, 52, 8'h02, 1'b0};
    vecs[15] = '{"0 lsd shown",      0,     100, 50, 132, 52, 8'h12, 1'b0};
    vecs[16] = '{"0 lsd col3",       0,     100, 50, 135, 52, 8'h12, 1'b1};
  end

  initial begin
    bit saw_ready;
    Reset_n  = 1'b1;
    load     = 1'b0;
    value_in = '0;
    origin_x = '0; origin_y = '0; DrawX = '0; DrawY = '0;
    #1 Reset_n = 1'b0;
    load     = 1'b1;
    value_in = 16'($urandom);
    DrawX    = 10'($urandom);
    DrawY    = 10'($urandom);
    repeat (3) @(posedge Clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset pixel_on", 32'(pixel_on), 32'd0);
    chk("reset digits", 32'(digits_out), 32'h00000);
    @(negedge Clk);
    load = 1'b0;
    Reset_n = 1'b1;
    probe("post-reset zero glyph", 0, 0, 32, 5, 8'h15, model_pix(0, 0, 0, 32, 5));

    convert(12345);
    convert(65535);
    convert(0);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].val != cur_val) convert(vecs[i].val);
      probe(vecs[i].nm, vecs[i].ox, vecs[i].oy, vecs[i].dx, vecs[i].dy, vecs[i].ea, vecs[i].ep);
    end

    // Load held high: 500 converts while value_in changes; re-accept in the ready cycle.
    @(negedge Clk);
    value_in = 16'd500;
    load = 1'b1;
    @(posedge Clk);
    for (int i = 1; i < VW; i++) begin
      @(posedge Clk);
      #1 chk("held-load busy", 32'(busy), 32'd1);
      if (i == 8) value_in = 16'd999;
    end
    @(posedge Clk);
    #1 chk("held-load ready", {30'd0, busy, ready}, 32'b01);
    chk("held-load digits", 32'(digits_out), 32'h00500);
    @(posedge Clk);
    #1 load = 1'b0;
    chk("re-accept in ready cycle", {30'd0, busy, ready}, 32'b10);
    for (int i = 1; i < VW; i++) @(posedge Clk);
    #1 chk("second not early", 32'(ready), 32'd0);
    @(posedge Clk);
    #1 chk("second ready", 32'(ready), 32'd1);
    chk("second digits", 32'(digits_out), 32'h00999);
    cur_val = 999;

    // Reset at iteration 8 aborts the conversion and clears the committed digits.
    @(negedge Clk);
    value_in = 16'd777;
    load = 1'b1;
    @(posedge Clk);
    #1 load = 1'b0;
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("abort digits", 32'(digits_out), 32'h00000);
    chk("abort busy/ready", {30'd0, busy, ready}, 32'b00);
    @(negedge Clk);
    Reset_n = 1'b1;
    saw_ready = 1'b0;
    repeat (20) begin
      @(posedge Clk);
      #1 if (ready) saw_ready = 1'b1;
    end
    chk("no ready after abort", 32'(saw_ready), 32'd0);
    chk("digits stay zero", 32'(digits_out), 32'h00000);
    cur_val = 0;

    // Random values and random pixel positions around the box.
    for (int r = 0; r < 6; r++) begin
      int v;
      v = (r % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 999));
      convert(v);
      for (int p = 0; p < 12; p++) begin
        int ox, oy, dx, dy;
        ox = int'($urandom_range(0, 1023));
        oy = int'($urandom_range(0, 1023));
        dx = (ox + int'($urandom_range(0, 50)) - 5) & 1023;
        dy = (oy + int'($urandom_range(0, 20)) - 2) & 1023;
        probe("random pixel", ox, oy, dx, dy, model_addr(v, ox, oy, dx, dy),
              model_pix(v, ox, oy, dx, dy));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
